// File: rtl/control_param_latch.sv
// control_param_latch: holds the seven ADC control words in shadow registers and publishes them at a frame boundary.
// Latency: rising i_Data_Received -> o_Pending next cycle; i_Frame_Boundary -> o_Update and new outputs two cycles later.
// Backpressure: none; a newer frame overwrites one that has not been applied. FREQ_SMOOTH_EN adds a frequency slew.
module control_param_latch #(
  parameter int          DIV_BIT         = 11,
  parameter logic [7:0]  NO_OF_HARMONICS = 8'd100,
  parameter logic [15:0] RESET_FREQUENCY = 16'd90,
  parameter int          SMOOTH_SHIFT    = 3
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic [15:0]        i_Data0,
  input  logic [15:0]        i_Data1,
  input  logic [15:0]        i_Data2,
  input  logic [15:0]        i_Data3,
  input  logic [15:0]        i_Data4,
  input  logic [15:0]        i_Data5,
  input  logic [15:0]        i_Data6,
  input  logic               i_Data_Received,
  input  logic               i_Frame_Boundary,
  output logic [15:0]        o_Frequency,
  output logic [DIV_BIT-1:0] o_Harmonic_Scale0,
  output logic [DIV_BIT-1:0] o_Harmonic_Scale1,
  output logic [DIV_BIT-1:0] o_Scale_Initial0,
  output logic [DIV_BIT-1:0] o_Scale_Initial1,
  output logic [15:0]        o_Freq_Scale,
  output logic [7:0]         o_Harmonic_Count,
  output logic               o_Update,
  output logic               o_Pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } state_t;

  state_t             r_State;
  state_t             w_Next_State;
  logic               r_Prev_Received;
  logic               w_Capture;
  logic               w_Apply;
  logic [7:0]         w_Clamped_Count;

  logic [15:0]        r_Sh_Frequency;
  logic [DIV_BIT-1:0] r_Sh_Harmonic_Scale0;
  logic [DIV_BIT-1:0] r_Sh_Harmonic_Scale1;
  logic [DIV_BIT-1:0] r_Sh_Scale_Initial0;
  logic [DIV_BIT-1:0] r_Sh_Scale_Initial1;
  logic [15:0]        r_Sh_Freq_Scale;
  logic [7:0]         r_Sh_Harmonic_Count;

  assign w_Capture       = i_Data_Received & ~r_Prev_Received;
  assign w_Apply         = (r_State == APPLY);
  assign o_Pending       = (r_State == PENDING);
  assign w_Clamped_Count = (i_Data6 > {8'd0, NO_OF_HARMONICS}) ? NO_OF_HARMONICS : i_Data6[7:0];

  // Remember last level of the receiver flag; resets high so a level already up is not a new frame.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Prev_Received <= 1'b1;
    end else begin
      r_Prev_Received <= i_Data_Received;
    end
  end

  // State register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State <= IDLE;
    end else begin
      r_State <= w_Next_State;
    end
  end

  // Next state: a boundary only matters once a frame is waiting; a capture during APPLY re-arms PENDING.
  always_comb begin
    w_Next_State = r_State;
    case (r_State)
      IDLE:    if (w_Capture) w_Next_State = PENDING;
      PENDING: if (i_Frame_Boundary) w_Next_State = APPLY;
      APPLY:   w_Next_State = w_Capture ? PENDING : IDLE;
      default: w_Next_State = IDLE;
    endcase
  end

  // Shadow copy of the newest frame; a later frame simply overwrites an unapplied one.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Sh_Frequency       <= RESET_FREQUENCY;
      r_Sh_Harmonic_Scale0 <= '0;
      r_Sh_Harmonic_Scale1 <= '0;
      r_Sh_Scale_Initial0  <= '0;
      r_Sh_Scale_Initial1  <= '0;
      r_Sh_Freq_Scale      <= '0;
      r_Sh_Harmonic_Count  <= NO_OF_HARMONICS;
    end else if (w_Capture) begin
      r_Sh_Frequency       <= i_Data0;
      r_Sh_Harmonic_Scale0 <= i_Data1[DIV_BIT-1:0];
      r_Sh_Scale_Initial0  <= i_Data2[DIV_BIT-1:0];
      r_Sh_Harmonic_Scale1 <= i_Data3[DIV_BIT-1:0];
      r_Sh_Scale_Initial1  <= i_Data4[DIV_BIT-1:0];
      r_Sh_Freq_Scale      <= i_Data5;
      r_Sh_Harmonic_Count  <= w_Clamped_Count;
    end
  end

  // Published registers change together in the APPLY cycle, flagged by a one-cycle o_Update.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Harmonic_Scale0 <= '0;
      o_Harmonic_Scale1 <= '0;
      o_Scale_Initial0  <= '0;
      o_Scale_Initial1  <= '0;
      o_Freq_Scale      <= '0;
      o_Harmonic_Count  <= NO_OF_HARMONICS;
      o_Update          <= 1'b0;
    end else begin
      o_Update <= w_Apply;
      if (w_Apply) begin
        o_Harmonic_Scale0 <= r_Sh_Harmonic_Scale0;
        o_Harmonic_Scale1 <= r_Sh_Harmonic_Scale1;
        o_Scale_Initial0  <= r_Sh_Scale_Initial0;
        o_Scale_Initial1  <= r_Sh_Scale_Initial1;
        o_Freq_Scale      <= r_Sh_Freq_Scale;
        o_Harmonic_Count  <= r_Sh_Harmonic_Count;
      end
    end
  end

`ifdef FREQ_SMOOTH_EN
  localparam int ACC_W = 16 + SMOOTH_SHIFT;

  logic [15:0]             r_Target;
  logic [ACC_W-1:0]        r_Acc;
  logic signed [ACC_W:0]   w_Delta;
  logic signed [ACC_W:0]   w_Step;
  logic                    unused_high_bits;

  // One extra bit keeps the difference signed across the full accumulator range.
  assign w_Delta     = $signed({1'b0, r_Target, {SMOOTH_SHIFT{1'b0}}}) - $signed({1'b0, r_Acc});
  assign w_Step      = w_Delta >>> SMOOTH_SHIFT;
  assign o_Frequency = r_Acc[ACC_W-1:SMOOTH_SHIFT];

  // Exponential slew toward the last applied frequency, one step per frame; snap once the step vanishes.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Target <= RESET_FREQUENCY;
      r_Acc    <= {RESET_FREQUENCY, {SMOOTH_SHIFT{1'b0}}};
    end else begin
      if (w_Apply) begin
        r_Target <= r_Sh_Frequency;
      end
      if (i_Frame_Boundary) begin
        if (w_Step == '0) begin
          r_Acc <= {r_Target, {SMOOTH_SHIFT{1'b0}}};
        end else begin
          r_Acc <= r_Acc + w_Step[ACC_W-1:0];
        end
      end
    end
  end

  assign unused_high_bits = ^{i_Data1 >> DIV_BIT, i_Data2 >> DIV_BIT, i_Data3 >> DIV_BIT,
                              i_Data4 >> DIV_BIT, w_Step[ACC_W]};
`else
  logic unused_high_bits;

  // Frequency is published with the rest of the frame.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Frequency <= RESET_FREQUENCY;
    end else if (w_Apply) begin
      o_Frequency <= r_Sh_Frequency;
    end
  end

  assign unused_high_bits = ^{i_Data1 >> DIV_BIT, i_Data2 >> DIV_BIT, i_Data3 >> DIV_BIT,
                              i_Data4 >> DIV_BIT, 32'(SMOOTH_SHIFT)};
`endif

endmodule

// File: tb/tb_control_param_latch.sv
// Bench for control_param_latch: directed vector table, hand sequences, random traffic vs a frame-level model.
`timescale 1ns/1ps
module tb_control_param_latch;

  localparam int SH = 3;

  logic        clk;
  logic        rst;
  logic [15:0] d0, d1, d2, d3, d4, d5, d6;
  logic        dr, fb;
  logic [15:0] o_freq, o_fs;
  logic [10:0] o_hs0, o_hs1, o_si0, o_si1;
  logic [7:0]  o_hc;
  logic        o_upd, o_pend;

  int n_checks = 0;
  int n_fail   = 0;

  control_param_latch #(
    .DIV_BIT(11), .NO_OF_HARMONICS(8'd100), .RESET_FREQUENCY(16'd90), .SMOOTH_SHIFT(SH)
  ) dut (
    .i_Clock(clk), .i_Reset(rst),
    .i_Data0(d0), .i_Data1(d1), .i_Data2(d2), .i_Data3(d3), .i_Data4(d4), .i_Data5(d5), .i_Data6(d6),
    .i_Data_Received(dr), .i_Frame_Boundary(fb),
    .o_Frequency(o_freq), .o_Harmonic_Scale0(o_hs0), .o_Harmonic_Scale1(o_hs1),
    .o_Scale_Initial0(o_si0), .o_Scale_Initial1(o_si1), .o_Freq_Scale(o_fs),
    .o_Harmonic_Count(o_hc), .o_Update(o_upd), .o_Pending(o_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] freq;
    logic [10:0] hs0, si0, hs1, si1;
    logic [15:0] fs;
    logic [7:0]  hc;
  } frame_t;

  // ---------------- reference model (frame level) ----------------
  frame_t m_pub, m_latest, m_snap;
  bit     m_prev, m_pending, m_flight, m_upd, model_on;
  int     m_acc, m_tgt;

  function automatic frame_t reset_frame();
    frame_t f;
    f = '0;
    f.freq = 16'd90;
    f.hc   = 8'd100;
    return f;
  endfunction

  function automatic frame_t frame_of_inputs();
    frame_t f;
    f.freq = d0;
    f.hs0  = 11'(d1 % 16'd2048);
    f.si0  = 11'(d2 % 16'd2048);
    f.hs1  = 11'(d3 % 16'd2048);
    f.si1  = 11'(d4 % 16'd2048);
    f.fs   = d5;
    f.hc   = (d6 > 16'd100) ? 8'd100 : 8'(d6);
    return f;
  endfunction

  task automatic model_step();
    bit cap;
    int delta, stp;
    if (rst) begin
      m_prev = 1'b1; m_pending = 1'b0; m_flight = 1'b0; m_upd = 1'b0;
      m_pub = reset_frame(); m_latest = reset_frame();
      m_acc = 90 * 8; m_tgt = 90;
    end else begin
      cap = dr && !m_prev;
      m_prev = dr;
      if (fb) begin
        delta = m_tgt * 8 - m_acc;
        stp = delta >>> SH;
        if (stp == 0) m_acc = m_tgt * 8;
        else m_acc = m_acc + stp;
      end
      if (cap) m_latest = frame_of_inputs();
      m_upd = 1'b0;
      if (m_flight) begin
        m_pub = m_snap; m_tgt = int'(m_snap.freq); m_upd = 1'b1;
        m_flight = 1'b0; m_pending = cap;
      end else if (m_pending && fb) begin
        m_snap = m_latest; m_flight = 1'b1; m_pending = 1'b0;
      end else if (cap) begin
        m_pending = 1'b1;
      end
    end
  endtask

  function automatic logic [15:0] model_freq();
`ifdef FREQ_SMOOTH_EN
    return 16'(m_acc >>> SH);
`else
    return m_pub.freq;
`endif
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic frame_t dut_frame();
    frame_t f;
    f.freq = o_freq; f.hs0 = o_hs0; f.si0 = o_si0; f.hs1 = o_hs1; f.si1 = o_si1;
    f.fs = o_fs; f.hc = o_hc;
    return f;
  endfunction

  // One clock: model follows the edge, outputs are sampled at the falling edge.
  task automatic tick();
    frame_t e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (model_on) begin
      e = m_pub;
      e.freq = model_freq();
      n_checks++;
      if (dut_frame() !== e) begin
        n_fail++;
        $display("FAIL model.outputs: got %h, expected %h", dut_frame(), e);
      end
      chk("model.update", 32'(o_upd), 32'(m_upd));
      chk("model.pending", 32'(o_pend), 32'(m_pending));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int dr, fb, d0, d1, d6;
    int e_freq, e_hs0, e_hc, e_upd, e_pend;
  } vec_t;

  vec_t tbl[33];

  function automatic vec_t mk(int a_dr, int a_fb, int a_d0, int a_d1, int a_d6,
                              int a_f, int a_h, int a_c, int a_u, int a_p);
    vec_t v;
    v.dr = a_dr; v.fb = a_fb; v.d0 = a_d0; v.d1 = a_d1; v.d6 = a_d6;
    v.e_freq = a_f; v.e_hs0 = a_h; v.e_hc = a_c; v.e_upd = a_u; v.e_pend = a_p;
    return v;
  endfunction

  initial begin
    int prev_f, nb;
    bit reached;
    model_on = 1'b0;
    rst = 1'b1; dr = 1'b1; fb = 1'b0;
    d0 = 16'h1111; d1 = 16'hFFFF; d2 = 16'h1234; d3 = 16'hFFFF; d4 = 16'h0800; d5 = 16'hBEEF; d6 = 16'd55;

    //          dr fb  d0    d1      d6   freq  hs0    hc  upd pend
    tbl[0]  = mk(0, 0, 1200, 'h0F3C, 40,  90,   0,     100, 0, 0);
    tbl[1]  = mk(1, 0, 1200, 'h0F3C, 40,  90,   0,     100, 0, 1);
    tbl[2]  = mk(1, 0, 1200, 'h0F3C, 40,  90,   0,     100, 0, 1);
    tbl[3]  = mk(0, 1, 1200, 'h0F3C, 40,  90,   0,     100, 0, 0);
    tbl[4]  = mk(0, 0, 1200, 'h0F3C, 40,  1200, 'h73C, 40,  1, 0);
    tbl[5]  = mk(0, 0, 1200, 'h0F3C, 40,  1200, 'h73C, 40,  0, 0);
    tbl[6]  = mk(1, 0, 300,  1,      250, 1200, 'h73C, 40,  0, 1);
    tbl[7]  = mk(0, 1, 300,  1,      250, 1200, 'h73C, 40,  0, 0);
    tbl[8]  = mk(0, 0, 300,  1,      250, 300,  1,     100, 1, 0);
    tbl[9]  = mk(0, 0, 300,  1,      250, 300,  1,     100, 0, 0);
    tbl[10] = mk(1, 0, 500,  2,      50,  300,  1,     100, 0, 1);
    tbl[11] = mk(0, 0, 500,  2,      50,  300,  1,     100, 0, 1);
    tbl[12] = mk(1, 0, 700,  'h0ABC, 7,   300,  1,     100, 0, 1);
    tbl[13] = mk(0, 1, 700,  'h0ABC, 7,   300,  1,     100, 0, 0);
    tbl[14] = mk(0, 0, 700,  'h0ABC, 7,   700,  'h2BC, 7,   1, 0);
    tbl[15] = mk(0, 0, 700,  'h0ABC, 7,   700,  'h2BC, 7,   0, 0);
    tbl[16] = mk(1, 1, 1000, 'h07FF, 100, 700,  'h2BC, 7,   0, 1);
    tbl[17] = mk(0, 0, 1000, 'h07FF, 100, 700,  'h2BC, 7,   0, 1);
    tbl[18] = mk(0, 0, 1000, 'h07FF, 100, 700,  'h2BC, 7,   0, 1);
    tbl[19] = mk(0, 1, 1000, 'h07FF, 100, 700,  'h2BC, 7,   0, 0);
    tbl[20] = mk(0, 0, 1000, 'h07FF, 100, 1000, 'h7FF, 100, 1, 0);
    tbl[21] = mk(0, 0, 1000, 'h07FF, 100, 1000, 'h7FF, 100, 0, 0);
    tbl[22] = mk(1, 0, 111,  5,      5,   1000, 'h7FF, 100, 0, 1);
    tbl[23] = mk(0, 0, 111,  5,      5,   1000, 'h7FF, 100, 0, 1);
    tbl[24] = mk(1, 1, 222,  6,      6,   1000, 'h7FF, 100, 0, 0);
    tbl[25] = mk(0, 0, 222,  6,      6,   222,  6,     6,   1, 0);
    tbl[26] = mk(1, 0, 333,  7,      7,   222,  6,     6,   0, 1);
    tbl[27] = mk(0, 1, 333,  7,      7,   222,  6,     6,   0, 0);
    tbl[28] = mk(1, 0, 444,  8,      8,   333,  7,     7,   1, 1);
    tbl[29] = mk(0, 1, 444,  8,      8,   333,  7,     7,   0, 0);
    tbl[30] = mk(0, 0, 444,  8,      8,   444,  8,     8,   1, 0);
    tbl[31] = mk(0, 0, 444,  8,      8,   444,  8,     8,   0, 0);
    tbl[32] = mk(0, 1, 444,  8,      8,   444,  8,     8,   0, 0);

    // Reset with the receiver flag already high.
    repeat (3) tick();
    chk("reset.freq", 32'(o_freq), 90);
    chk("reset.hc", 32'(o_hc), 100);
    chk("reset.hs0", 32'(o_hs0), 0);
    chk("reset.hs1", 32'(o_hs1), 0);
    chk("reset.si0", 32'(o_si0), 0);
    chk("reset.si1", 32'(o_si1), 0);
    chk("reset.fs", 32'(o_fs), 0);
    chk("reset.upd", 32'(o_upd), 0);
    chk("reset.pend", 32'(o_pend), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_high.pend", 32'(o_pend), 0);
    end
    fb = 1'b1; tick(); fb = 1'b0;
    chk("idle_boundary.upd", 32'(o_upd), 0);
    tick();
    chk("idle_boundary.upd2", 32'(o_upd), 0);
    chk("idle_boundary.hc", 32'(o_hc), 100);
    dr = 1'b0; tick();
    chk("drop_low.pend", 32'(o_pend), 0);

    // Directed vectors.
    for (int i = 0; i < 33; i++) begin
      dr = tbl[i].dr[0]; fb = tbl[i].fb[0];
      d0 = 16'(tbl[i].d0); d1 = 16'(tbl[i].d1); d6 = 16'(tbl[i].d6);
      tick();
`ifndef FREQ_SMOOTH_EN
      chk($sformatf("tbl[%0d].freq", i), 32'(o_freq), tbl[i].e_freq);
`endif
      chk($sformatf("tbl[%0d].hs0", i), 32'(o_hs0), tbl[i].e_hs0);
      chk($sformatf("tbl[%0d].hc", i), 32'(o_hc), tbl[i].e_hc);
      chk($sformatf("tbl[%0d].upd", i), 32'(o_upd), tbl[i].e_upd);
      chk($sformatf("tbl[%0d].pend", i), 32'(o_pend), tbl[i].e_pend);
    end
    fb = 1'b0;

    // Reset while a frame is pending.
    dr = 1'b1; d0 = 16'd5555; d1 = 16'd99; d6 = 16'd9; tick();
    chk("midreset.pend_before", 32'(o_pend), 1);
    dr = 1'b0; rst = 1'b1; fb = 1'b1; tick();
    chk("midreset.pend", 32'(o_pend), 0);
    chk("midreset.freq", 32'(o_freq), 90);
    chk("midreset.hc", 32'(o_hc), 100);
    chk("midreset.hs0", 32'(o_hs0), 0);
    rst = 1'b0; tick(); fb = 1'b0; tick(); tick();
    chk("midreset.no_update", 32'(o_upd), 0);
    chk("midreset.hs0_after", 32'(o_hs0), 0);

    // Step from 90 to 890.
    dr = 1'b1; d0 = 16'd890; tick();
    dr = 1'b0; fb = 1'b1; tick();
    fb = 1'b0; tick();
    chk("step.upd", 32'(o_upd), 1);
`ifdef FREQ_SMOOTH_EN
    chk("step.freq_at_apply", 32'(o_freq), 90);
    prev_f = 90; reached = 1'b0; nb = 0;
    for (int k = 0; k < 60 && !reached; k++) begin
      fb = 1'b1; tick(); fb = 1'b0; tick();
      nb++;
      if (k == 0) chk("smooth.first", 32'(o_freq), 190);
      chk("smooth.monotonic", (int'(o_freq) >= prev_f) ? 32'd1 : 32'd0, 32'd1);
      prev_f = int'(o_freq);
      if (o_freq == 16'd890) reached = 1'b1;
    end
    chk("smooth.reached_890", 32'(reached), 1);
    fb = 1'b1; tick(); fb = 1'b0; tick();
    chk("smooth.settled", 32'(o_freq), 890);
`else
    chk("step.freq", 32'(o_freq), 890);
    fb = 1'b1; tick(); fb = 1'b0; tick();
    chk("step.freq_stays", 32'(o_freq), 890);
    nb = 0; prev_f = 0; reached = 1'b0;
`endif

    // Random traffic against the model.
    model_on = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 2) == 0) dr = ~dr;
      fb = ($urandom_range(0, 5) == 0);
      d0 = 16'($urandom); d1 = 16'($urandom); d2 = 16'($urandom);
      d3 = 16'($urandom); d4 = 16'($urandom); d5 = 16'($urandom);
      d6 = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 200)) : 16'($urandom);
      tick();
    end
    rst = 1'b0; fb = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
